// File: rtl/fetch.sv
// Instruction fetch stage: issues word fetches, queues returned instructions with
// their PCs in order, and flushes/drains cleanly on control-flow redirects.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];
  localparam logic [CW:0]   CAP  = DEPTH[CW:0];
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, resp_pc, target;
  logic [CW-1:0] count, outstanding, outstanding_next;
  logic [CW:0]   in_use;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic          accept, push, pop, head_valid;

  assign target = {redirect_pc_i[31:2], 2'b00};

  // Credit rule: queued plus in-flight never exceeds DEPTH, so a response always has a slot.
  assign in_use      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = (state == RUN) & ~redirect_i & ~rst_i & (in_use < CAP);
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o & imem_gnt_i;

  assign push          = imem_rvalid_i & (state == RUN) & ~redirect_i;
  assign head_valid    = (count != '0) & ~rst_i;
  assign instr_valid_o = head_valid & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = head_valid ? q_instr[rd_ptr] : NOP;
  assign pc_o          = head_valid ? q_pc[rd_ptr]    : 32'h0;

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rvalid_i);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (redirect_i) begin
      state_next = (outstanding_next != '0) ? DRAIN : RUN;
    end else if ((state == DRAIN) && (outstanding_next == '0)) begin
      state_next = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (redirect_i) begin
        fetch_pc <= target;
        resp_pc  <= target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata_i;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count == FULL)));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order memory model with one-cycle minimum
// response latency, plus hand-computed expectations for each scenario.
module tb_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic hold;
  logic [31:0] pend[$];
  logic [31:0] grants[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Record this cycle's handshakes, cross the clock edge, then drive the next response.
  task automatic tick();
    #1;
    if (imem_rvalid_i && pend.size() > 0) pend.delete(0);
    if (imem_req_o && imem_gnt_i) begin
      pend.push_back(imem_addr_o);
      grants.push_back(imem_addr_o);
    end
    if (instr_valid_o && instr_ready_i) begin
      pop_pc.push_back(pc_o);
      pop_instr.push_back(instr_o);
    end
    @(posedge clk_i);
    if (rst_i) pend.delete();
    @(negedge clk_i);
    imem_rvalid_i = !hold && (pend.size() > 0);
    imem_rdata_i  = imem_rvalid_i ? mem_data(pend[0]) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    hold          = 1'b0;
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    tick();
    grants.delete();
    pop_pc.delete();
    pop_instr.delete();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    hold          = 1'b0;
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    @(negedge clk_i);

    // Outputs held quiet during reset
    #1;
    check("rst_req",   32'(imem_req_o),    32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o,            32'h0000_0013);
    check("rst_pc",    pc_o,               32'h0);

    // Streaming with ready high
    do_reset();
    #1;
    check("s1_a0_req",  32'(imem_req_o), 32'd1);
    check("s1_a0_addr", imem_addr_o,     32'h0);
    check("s1_a0_valid", 32'(instr_valid_o), 32'd0);
    tick();
    #1;
    check("s1_a1_valid", 32'(instr_valid_o), 32'd0);
    tick();
    #1;
    check("s1_a2_valid", 32'(instr_valid_o), 32'd1);
    check("s1_a2_pc",    pc_o,    32'h0);
    check("s1_a2_instr", instr_o, mem_data(32'h0));
    tick();
    repeat (5) tick();
    check("s1_ngrant", 32'(grants.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("s1_grant%0d", i), grants[i], 32'(4 * i));
    check("s1_npop", 32'(pop_pc.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s1_pop_pc%0d", i),    pop_pc[i],    32'(4 * i));
      check($sformatf("s1_pop_instr%0d", i), pop_instr[i], mem_data(32'(4 * i)));
    end

    // Decode stalled: credit cap stops issue, head stays stable
    do_reset();
    instr_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 2) begin
        check("s2_a2_valid", 32'(instr_valid_o), 32'd1);
        check("s2_a2_pc",    pc_o, 32'h0);
      end
      if (c == 9) begin
        check("s2_a9_req",   32'(imem_req_o),    32'd0);
        check("s2_a9_valid", 32'(instr_valid_o), 32'd1);
        check("s2_a9_pc",    pc_o,    32'h0);
        check("s2_a9_instr", instr_o, mem_data(32'h0));
      end
      tick();
    end
    check("s2_ngrant", 32'(grants.size()), 32'd2);
    instr_ready_i = 1'b1;
    #1;
    check("s2_pop_cycle_req", 32'(imem_req_o), 32'd0);
    tick();
    #1;
    check("s2_resume_req",  32'(imem_req_o), 32'd1);
    check("s2_resume_addr", imem_addr_o,     32'h8);
    tick();

    // Redirect with two requests in flight: drain, then fetch target
    do_reset();
    tick(); tick(); tick();
    hold = 1'b1;
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    check("s3_grant2",   grants[2], 32'h8);
    check("s3_grant3",   grants[3], 32'hC);
    check("s3_rd_req",   32'(imem_req_o),    32'd0);
    check("s3_rd_valid", 32'(instr_valid_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    hold       = 1'b0;
    #1;
    check("s3_drain_req0", 32'(imem_req_o), 32'd0);
    tick();
    #1;
    check("s3_drain_req1",   32'(imem_req_o),    32'd0);
    check("s3_drain_valid1", 32'(instr_valid_o), 32'd0);
    tick();
    #1;
    check("s3_drain_req2",   32'(imem_req_o),    32'd0);
    check("s3_drain_valid2", 32'(instr_valid_o), 32'd0);
    tick();
    #1;
    check("s3_run_req",   32'(imem_req_o),    32'd1);
    check("s3_run_addr",  imem_addr_o,        32'h100);
    check("s3_run_valid", 32'(instr_valid_o), 32'd0);
    tick();
    tick();
    #1;
    check("s3_new_valid", 32'(instr_valid_o), 32'd1);
    check("s3_new_pc",    pc_o,    32'h100);
    check("s3_new_instr", instr_o, mem_data(32'h100));
    tick();

    // Redirect coinciding with the only outstanding response
    do_reset();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    #1;
    check("s4_rd_req", 32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    check("s4_req",   32'(imem_req_o),    32'd1);
    check("s4_addr",  imem_addr_o,        32'h200);
    check("s4_valid", 32'(instr_valid_o), 32'd0);
    tick();
    tick();
    #1;
    check("s4_head_pc",    pc_o,    32'h200);
    check("s4_head_instr", instr_o, mem_data(32'h200));
    tick();

    // Grant withheld for five cycles
    do_reset();
    imem_gnt_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 0 || c == 4) begin
        check($sformatf("s5_wait%0d_req", c),  32'(imem_req_o), 32'd1);
        check($sformatf("s5_wait%0d_addr", c), imem_addr_o,     32'h0);
      end
      tick();
    end
    imem_gnt_i = 1'b1;
    #1;
    check("s5_gnt_addr",   imem_addr_o,          32'h0);
    check("s5_no_grants",  32'(grants.size()),   32'd0);
    tick();
    #1;
    check("s5_next_addr", imem_addr_o, 32'h4);
    tick();

    // Reset with a full queue
    do_reset();
    instr_ready_i = 1'b0;
    repeat (5) tick();
    #1;
    check("s6_full_valid", 32'(instr_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("s6_rst_valid", 32'(instr_valid_o), 32'd0);
    check("s6_rst_instr", instr_o, 32'h0000_0013);
    check("s6_rst_req",   32'(imem_req_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("s6_post_valid", 32'(instr_valid_o), 32'd0);
    check("s6_post_instr", instr_o, 32'h0000_0013);
    check("s6_post_pc",    pc_o,    32'h0);
    check("s6_post_req",   32'(imem_req_o), 32'd1);
    check("s6_post_addr",  imem_addr_o,     32'h0);
    tick();

    // Redirect to the last word, low bits ignored, then PC wraps
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    #1;
    check("s7_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    #1;
    check("s7_addr_wrap", imem_addr_o, 32'h0);
    tick();
    #1;
    check("s7_head_pc",    pc_o,    32'hFFFF_FFFC);
    check("s7_head_instr", instr_o, 32'h0000_0003);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
